fp_div: RTL and testbench

FP_DIV -- requirements
Module: fp_div

---
 rtl/fp_div_pkg.sv | 12 +
 rtl/fp_div_classify.sv | 28 ++
 rtl/fp_div.sv | 169 ++++++++++++++++
 tb/tb_fp_div.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision iterative divider.
package fp_div_pkg;

    localparam int          ITER_COUNT_DEF = 26;
    localparam int          EXP_BIAS       = 127;
    localparam logic [31:0] QNAN           = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_e;

    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} cls_e;

endpackage

// File: rtl/fp_div_classify.sv
// Combinational operand unpack: class, sign, exponent and 24-bit mantissa.
// Denormals flush to signed zero; non-normal classes report a zero mantissa.
module fp_div_classify
    import fp_div_pkg::*;
(
    input  logic [31:0] op,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] mant,
    output cls_e        cls
);

    always_comb begin
        sign = op[31];
        exp  = op[30:23];
        mant = {1'b1, op[22:0]};
        cls  = NORMAL;
        if (op[30:23] == 8'hFF) begin
            cls  = (op[22:0] != 23'd0) ? NAN : INF;
            mant = '0;
        end else if (op[30:23] == 8'h00) begin
            cls  = ZERO;
            exp  = '0;
            mant = '0;
        end
    end

endmodule

// File: rtl/fp_div.sv
// IEEE-754 single divider: restoring radix-2, one quotient bit per enabled cycle.
// Latency ITER_COUNT+2 enabled cycles from accept; result held in DONE until out_ready.
module fp_div
    import fp_div_pkg::*;
#(
    parameter int ITER_COUNT = ITER_COUNT_DEF
) (
    input  logic        clk,
    input  logic        aclr_n,
    input  logic        ena,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ay,
    input  logic [31:0] az,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        div_by_zero
);

    localparam int CW     = $clog2(ITER_COUNT + 1);
    localparam int LSB    = ITER_COUNT - 24;
    localparam int GRD    = ITER_COUNT - 25;
    localparam int STK_HI = ITER_COUNT - 26;

    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_mant, b_mant;
    cls_e        a_cls, b_cls;

    fp_div_classify u_cls_a (.op(ay), .sign(a_sign), .exp(a_exp), .mant(a_mant), .cls(a_cls));
    fp_div_classify u_cls_b (.op(az), .sign(b_sign), .exp(b_exp), .mant(b_mant), .cls(b_cls));

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    sign_q, sign_d;
    cls_e                    cls_a_q, cls_a_d, cls_b_q, cls_b_d;
    logic signed [9:0]       exp_q, exp_d;
    logic [24:0]             rem_q, rem_d;
    logic [23:0]             div_q, div_d;
    logic [ITER_COUNT-1:0]   quo_q, quo_d;
    logic [31:0]             result_q, result_d;
    logic                    dbz_q, dbz_d;

    logic                    pre_shift, rnd_up, sticky;
    logic [24:0]             mant_sum;
    logic [23:0]             mant_rnd;
    logic [31:0]             fin_res;

    always_comb begin
        pre_shift = a_mant < b_mant;
        sticky    = (|quo_q[STK_HI:0]) | (|rem_q);
        rnd_up    = quo_q[GRD] & (sticky | quo_q[LSB]);
        mant_sum  = {1'b0, quo_q[ITER_COUNT-1 -: 24]} + {24'd0, rnd_up};
        mant_rnd  = mant_sum[24] ? mant_sum[24:1] : mant_sum[23:0];
        // Exponent range checks run on the already-rounded exponent.
        if (exp_q >= 10'sd255)
            fin_res = {sign_q, 8'hFF, 23'd0};
        else if (exp_q <= 10'sd0)
            fin_res = {sign_q, 31'd0};
        else
            fin_res = {sign_q, exp_q[7:0], quo_q[ITER_COUNT-2 -: 23]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        cls_a_d  = cls_a_q;
        cls_b_d  = cls_b_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        if (ena) begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d = ITER;
                    cnt_d   = '0;
                    sign_d  = a_sign ^ b_sign;
                    cls_a_d = a_cls;
                    cls_b_d = b_cls;
                    // Pre-shift keeps the quotient in [1,2) so its MSB is the hidden bit.
                    rem_d   = pre_shift ? {a_mant, 1'b0} : {1'b0, a_mant};
                    div_d   = b_mant;
                    exp_d   = 10'(a_exp) - 10'(b_exp) + 10'(EXP_BIAS) - {9'd0, pre_shift};
                    quo_d   = '0;
                end
                ITER: begin
                    if (rem_q >= {1'b0, div_q}) begin
                        rem_d = (rem_q - {1'b0, div_q}) << 1;
                        quo_d = {quo_q[ITER_COUNT-2:0], 1'b1};
                    end else begin
                        rem_d = rem_q << 1;
                        quo_d = {quo_q[ITER_COUNT-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER_COUNT - 1)) begin
                        state_d = ROUND;
                        cnt_d   = '0;
                    end
                end
                ROUND: begin
                    // Phase 0 rounds in place; phase 1 packs and resolves specials.
                    if (cnt_q == '0) begin
                        quo_d[ITER_COUNT-1 -: 24] = mant_rnd;
                        exp_d = exp_q + {9'd0, mant_sum[24]};
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = DONE;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        if (cls_a_q == NAN || cls_b_q == NAN ||
                            (cls_a_q == ZERO && cls_b_q == ZERO) ||
                            (cls_a_q == INF && cls_b_q == INF))
                            result_d = QNAN;
                        else if (cls_a_q == INF)
                            result_d = {sign_q, 8'hFF, 23'd0};
                        else if (cls_b_q == ZERO) begin
                            result_d = {sign_q, 8'hFF, 23'd0};
                            dbz_d    = 1'b1;
                        end else if (cls_a_q == ZERO || cls_b_q == INF)
                            result_d = {sign_q, 31'd0};
                        else
                            result_d = fin_res;
                    end
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            cls_a_q  <= ZERO;
            cls_b_q  <= ZERO;
            exp_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            cls_a_q  <= cls_a_d;
            cls_b_q  <= cls_b_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fp_div.sv
// Directed-vector bench for fp_div: results, latency, handshake, clock enable and reset.
module tb_fp_div;

    logic        clk;
    logic        aclr_n;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ay;
    logic [31:0] az;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero;

    int n_chk = 0;
    int n_err = 0;

    fp_div dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ay         (ay),
        .az         (az),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept one operand pair, optionally stall ena for stall_len cycles starting
    // stall_at cycles after accept, then check latency, result and div_by_zero.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic exp_dbz,
                           input int stall_at, input int stall_len, input int exp_lat);
        int lat;
        @(negedge clk);
        ay = a; az = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            ena = !(lat >= stall_at && lat < stall_at + stall_len);
            @(posedge clk); #1;
            lat++;
        end
        ena = 1'b1;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        aclr_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ay = '0; az = '0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        aclr_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_div("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 0, 0, 28);
        run_div("one_by_three",32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 0, 0, 28);
        run_div("overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 0, 0, 28);
        run_div("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 0, 0, 28);
        run_div("zero_by_zero",32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 0, 0, 28);
        run_div("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 0, 0, 28);
        run_div("inf_by_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 0, 0, 28);
        run_div("inf_by_two",  32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 0, 0, 28);
        run_div("one_by_inf",  32'hBF800000, 32'h7F800000, 32'h80000000, 1'b0, 0, 0, 28);
        run_div("denorm_a",    32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 0, 0, 28);
        run_div("denorm_b",    32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1, 0, 0, 28);
        run_div("underflow",   32'h00800000, 32'h40800000, 32'h00000000, 1'b0, 0, 0, 28);
        run_div("neg_six",     32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 0, 0, 28);
        run_div("seven_half",  32'h40E00000, 32'h40000000, 32'h40600000, 1'b0, 0, 0, 28);
        run_div("one_by_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 0, 0, 28);
        run_div("ena_stall",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 5, 5, 33);

        // Hold the result in DONE with out_ready low while new operands are offered.
        @(negedge clk);
        ay = 32'h40C00000; az = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        ay = 32'h3F800000; az = 32'h40400000;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_result", result, 32'h40400000);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        check("hold_still_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset partway through iteration discards the division.
        @(negedge clk);
        ay = 32'h40E00000; az = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        aclr_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        aclr_n = 1'b1;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        run_div("after_rst",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 0, 0, 28);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
